// File: rtl/power_seq_gen_pkg.sv
// Shared types and defaults for the power sequence generator.
//   Provides the FSM state encoding, default widths and the product-width helper.
package power_seq_gen_pkg;

   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned DEF_BASE_W = 8;
   localparam int unsigned DEF_EXP_W  = 6;
   localparam int unsigned DEF_PROD_W = DEF_DATA_W + DEF_BASE_W;

   // FSM state encoding, kept as plain constants for legacy tool flows
   typedef logic [1:0] state_t;
   localparam state_t S_IDLE = 2'd0;
   localparam state_t S_EMIT = 2'd1;
   localparam state_t S_GAP  = 2'd2;
   localparam state_t S_DONE = 2'd3;

   // Width of the full unsigned product power*base
   function automatic int unsigned prod_w(input int unsigned data_w, input int unsigned base_w);
      return data_w + base_w;
   endfunction

endpackage

// File: rtl/power_seq_step.sv
// Combinational multiply-and-check for one sequence step.
//   i_power     : current term
//   i_base      : multiplier
//   o_product_c : product truncated to DATA_W bits
//   o_ovf_c     : product did not fit in DATA_W bits
module power_seq_step
   import power_seq_gen_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned BASE_W = DEF_BASE_W
) (
   input  logic [DATA_W-1:0] i_power,
   input  logic [BASE_W-1:0] i_base,
   output logic [DATA_W-1:0] o_product_c,
   output logic              o_ovf_c
);

   localparam int unsigned PROD_W = prod_w(DATA_W, BASE_W);

   logic [PROD_W-1:0] w_full;

   assign w_full      = PROD_W'(i_power) * PROD_W'(i_base);
   assign o_product_c = w_full[DATA_W-1:0];
   assign o_ovf_c     = |w_full[PROD_W-1:DATA_W];

endmodule

// File: rtl/power_seq_gen.sv
// Valid/ready source of the sequence base^0, base^1, base^2, ...
//   clk, rst (async, active-low); start restarts with latched base/wrap_mode;
//   enable gates the next term; out_ready is the downstream accept.
//   Outputs: out_valid, power, exponent, overflow (sticky), busy, done.
//   Optional: POWER_SEQ_GEN_EXP_LIMIT_EN adds max_exp, ending the sequence
//   after the term with exponent==max_exp transfers.
module power_seq_gen
   import power_seq_gen_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned BASE_W = DEF_BASE_W,
   parameter int unsigned EXP_W  = DEF_EXP_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              enable,
   input  logic [BASE_W-1:0] base,
   input  logic              wrap_mode,
`ifdef POWER_SEQ_GEN_EXP_LIMIT_EN
   input  logic [EXP_W-1:0]  max_exp,
`endif
   input  logic              out_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] power,
   output logic [EXP_W-1:0]  exponent,
   output logic              overflow,
   output logic              busy,
   output logic              done
);

   state_t            r_state,  w_state_nx;
   logic [BASE_W-1:0] r_base,   w_base_nx;
   logic              r_wrap,   w_wrap_nx;
   logic [DATA_W-1:0] r_power,  w_power_nx;
   logic [EXP_W-1:0]  r_exp,    w_exp_nx;
   logic              r_ovf,    w_ovf_nx;
   logic              r_valid,  w_valid_nx;
   logic              r_busy,   w_busy_nx;
   logic              r_done,   w_done_nx;
   logic [DATA_W-1:0] w_product;
   logic              w_step_ovf;
   logic              w_limit_hit;

`ifdef POWER_SEQ_GEN_EXP_LIMIT_EN
   logic [EXP_W-1:0]  r_max_exp, w_max_exp_nx;
   assign w_limit_hit = (r_exp == r_max_exp);
`else
   assign w_limit_hit = 1'b0;
`endif

   power_seq_step #(
      .DATA_W (DATA_W),
      .BASE_W (BASE_W)
   ) u_step (
      .i_power     (r_power),
      .i_base      (r_base),
      .o_product_c (w_product),
      .o_ovf_c     (w_step_ovf)
   );

   // State and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_base  <= '0;
         r_wrap  <= 1'b0;
         r_power <= '0;
         r_exp   <= '0;
         r_ovf   <= 1'b0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
`ifdef POWER_SEQ_GEN_EXP_LIMIT_EN
         r_max_exp <= '0;
`endif
      end else begin
         r_state <= w_state_nx;
         r_base  <= w_base_nx;
         r_wrap  <= w_wrap_nx;
         r_power <= w_power_nx;
         r_exp   <= w_exp_nx;
         r_ovf   <= w_ovf_nx;
         r_valid <= w_valid_nx;
         r_busy  <= w_busy_nx;
         r_done  <= w_done_nx;
`ifdef POWER_SEQ_GEN_EXP_LIMIT_EN
         r_max_exp <= w_max_exp_nx;
`endif
      end
   end

   // Next-state and next-register logic; status flags decode the next state
   always_comb begin
      w_state_nx = r_state;
      w_base_nx  = r_base;
      w_wrap_nx  = r_wrap;
      w_power_nx = r_power;
      w_exp_nx   = r_exp;
      w_ovf_nx   = r_ovf;
`ifdef POWER_SEQ_GEN_EXP_LIMIT_EN
      w_max_exp_nx = r_max_exp;
`endif

      if (start) begin
         w_base_nx  = base;
         w_wrap_nx  = wrap_mode;
         w_power_nx = DATA_W'(1);
         w_exp_nx   = '0;
         w_ovf_nx   = 1'b0;
         w_state_nx = S_EMIT;
`ifdef POWER_SEQ_GEN_EXP_LIMIT_EN
         w_max_exp_nx = max_exp;
`endif
      end else begin
         // advance: EMIT transfer with enable, or enable seen in GAP
         logic w_advance;
         w_advance = 1'b0;
         case (r_state)
            S_EMIT: begin
               if (out_ready) begin
                  if (w_limit_hit)  w_state_nx = S_DONE;
                  else if (enable)  w_advance  = 1'b1;
                  else              w_state_nx = S_GAP;
               end
            end
            S_GAP:   if (enable) w_advance = 1'b1;
            default: ;
         endcase

         if (w_advance) begin
            if (w_step_ovf) w_ovf_nx = 1'b1;
            if (w_step_ovf && !r_wrap) begin
               // stop mode: keep the last valid term on the outputs
               w_state_nx = S_DONE;
            end else begin
               w_power_nx = w_product;
               w_exp_nx   = r_exp + EXP_W'(1);
               w_state_nx = S_EMIT;
            end
         end
      end

      w_valid_nx = (w_state_nx == S_EMIT);
      w_busy_nx  = (w_state_nx == S_EMIT) || (w_state_nx == S_GAP);
      w_done_nx  = (w_state_nx == S_DONE);
   end

   assign out_valid = r_valid;
   assign power     = r_power;
   assign exponent  = r_exp;
   assign overflow  = r_ovf;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule

// File: doc/power_seq_gen.md
Name: power_seq_gen

Overview:
- Parametrised successor to the fixed base-3 power generator: emits the sequence base^0, base^1, base^2, ... with runtime base, configurable data width and overflow handling.
- Output is a valid/ready stream, so downstream consumers can stall the sequence.
- Sits as a stimulus/data source feeding arithmetic datapaths in the lab design.

Parameters:
- DATA_W, 32, width of the power output.
- BASE_W, 8, width of the runtime base input.
- EXP_W, 6, width of the exponent counter; wraps modulo 2^EXP_W.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  pulse: latch base/wrap_mode, restart the sequence.
- enable  in  1  permits generation of the next term.
- base  in  BASE_W  multiplier, sampled on start.
- wrap_mode  in  1  0 = stop on overflow, 1 = keep truncated product; sampled on start.
- out_ready  in  1  downstream accepts the current term.
- out_valid  out  1  power/exponent hold a valid term.
- power  out  DATA_W  current term.
- exponent  out  EXP_W  exponent of the current term.
- overflow  out  1  sticky; set when any product exceeded DATA_W bits.
- busy  out  1  high in EMIT or GAP.
- done  out  1  high while in DONE.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; power=0, exponent=0, out_valid=0, overflow=0, busy=0, done=0.
- States: IDLE, EMIT (out_valid=1), GAP (out_valid=0, term consumed, waiting for enable), DONE.
- start has priority in every state.
  - On the clock edge with start=1: latch base and wrap_mode; power<=1, exponent<=0, overflow<=0; go to EMIT.
  - First term is visible one cycle after start.
  - start while busy aborts the sequence and restarts it.
- EMIT:
  - Term and out_valid are held stable while out_ready=0.
  - On transfer (out_valid & out_ready): if enable=1, load the next term in the same edge and stay in EMIT. This gives full throughput, one term per cycle.
  - If enable=0 at transfer, go to GAP; power/exponent keep the last transferred term.
- GAP: first cycle with enable=1 loads the next term and goes to EMIT.
- Next-term computation:
  - full product = power*base, DATA_W+BASE_W bits, unsigned.
  - If upper BASE_W bits are nonzero: overflow<=1 (sticky).
    - wrap_mode=0: discard the product, go to DONE, out_valid<=0; power/exponent keep the last valid term.
    - wrap_mode=1: load the low DATA_W bits and continue.
  - exponent increments modulo 2^EXP_W.
- DONE: done=1, busy=0, out_valid=0; leaves only on start.
- IDLE: no terms are produced; enable and out_ready are ignored.
- Degenerate bases:
  - base=0 gives 1,0,0,... with no overflow.
  - base=1 gives 1 forever.

Optional Feature:
- Macro POWER_SEQ_GEN_EXP_LIMIT_EN.
- Defined:
  - Adds input max_exp[EXP_W-1:0], sampled on start.
  - When the term with exponent==max_exp transfers, go to DONE; no further terms.
  - Overflow-stop still applies if it occurs earlier.
  - max_exp=0 produces exactly one term (1).
- Undefined: port absent; the sequence ends only via overflow in stop mode, or never in wrap mode.

Decomposition:
- Package power_seq_gen_pkg:
  - state enum (IDLE, EMIT, GAP, DONE);
  - default DATA_W/BASE_W/EXP_W constants;
  - localparam for product width (DATA_W+BASE_W).
- Sub-module power_seq_step: combinational multiply-and-check, giving truncated product and overflow flag.
- FSM and registers stay in the top module.

Test Plan:
- Reset mid-sequence: start base=3, drop rst after 5 terms -> all outputs 0 immediately (asynchronous), state IDLE; release, start -> power=1, exponent=0 one cycle later.
- Stop mode: base=3, DATA_W=32, wrap_mode=0, out_ready=1, enable=1 -> 21 terms with the last at exponent=20, power=3486784401; then overflow=1, done=1, out_valid=0.
- Wrap mode: same as above with wrap_mode=1 -> exponent=21 gives power=1870418611 with overflow=1; the stream continues.
- Backpressure: base=2, out_ready low for 4 cycles at exponent=3 -> power holds 8 and out_valid holds 1; no term is lost or duplicated after release.
- Enable gap: enable=0 at the transfer of power=4 (base=2) -> GAP with out_valid=0; enable=1 two cycles later -> power=8, exponent=3.
- Restart and limit: start while busy with base=5 -> next term is 1; with POWER_SEQ_GEN_EXP_LIMIT_EN and max_exp=2 -> terms 1, 5, 25, then done=1.
